// File: rtl/enemy_jump_sched_if.sv
// Bundle of enemy state inputs, detector hookup and per-frame step outputs
// shared between the enemy jump scheduler and its neighbours.
interface enemy_jump_sched_if #(
  parameter int unsigned N_ENEMIES = 4
);
  logic                      frame_tick;
  logic [14*N_ENEMIES-1:0]   enemy_loc_all;
  logic [2*N_ENEMIES-1:0]    enemy_dir_all;
  logic [N_ENEMIES-1:0]      enemy_grounded;
  logic [13:0]               det_loc;
  logic [1:0]                det_dir;
  logic                      det_jump;
  logic                      scan_busy;
  logic                      step_valid;
  logic [4*N_ENEMIES-1:0]    y_step_all;
  logic [N_ENEMIES-1:0]      airborne;
  logic                      overrun;

  // Environment side: frame timing, enemy positions and the jump detector
  modport master (
    output frame_tick, enemy_loc_all, enemy_dir_all, enemy_grounded, det_jump,
    input  det_loc, det_dir, scan_busy, step_valid, y_step_all, airborne, overrun
  );

  // Scheduler side
  modport slave (
    input  frame_tick, enemy_loc_all, enemy_dir_all, enemy_grounded, det_jump,
    output det_loc, det_dir, scan_busy, step_valid, y_step_all, airborne, overrun
  );
endinterface

// File: rtl/enemy_jump_sched.sv
// Enemy jump scheduler: shares one combinational jump detector across all
// enemies once per frame, then advances a GROUND/RISE/FALL machine per enemy
// and publishes a signed 4-bit vertical step for each.
module enemy_jump_sched #(
  parameter int unsigned N_ENEMIES   = 4,
  parameter int unsigned RISE_FRAMES = 8,
  parameter int unsigned JUMP_STEP   = 2,
  parameter int unsigned FALL_STEP   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  enemy_jump_sched_if.slave  bus
);

  localparam int unsigned IDX_W  = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned LOC_W  = 14;
  localparam int unsigned DIR_W  = 2;

  // Two's-complement step encodings: upward motion is negative
  localparam logic [STEP_W-1:0] STEP_UP   = STEP_W'((2 ** STEP_W) - JUMP_STEP);
  localparam logic [STEP_W-1:0] STEP_DN   = STEP_W'(FALL_STEP);
  localparam logic [STEP_W-1:0] STEP_NONE = '0;
  localparam logic [CNT_W-1:0]  RISE_INIT = CNT_W'(RISE_FRAMES - 1);

  typedef enum logic [1:0] {
    SCH_IDLE   = 2'd0,
    SCH_SCAN   = 2'd1,
    SCH_UPDATE = 2'd2
  } sch_e;

  typedef enum logic [1:0] {
    EN_GROUND = 2'd0,
    EN_RISE   = 2'd1,
    EN_FALL   = 2'd2
  } en_e;

  // Scheduler state
  sch_e                    sch_q, sch_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_ENEMIES-1:0]    jump_flag_q, jump_flag_d;
  logic                    overrun_q, overrun_d;
  logic                    scan_busy_q, scan_busy_d;
  logic                    step_valid_q, step_valid_d;

  // Per-enemy state
  en_e                     en_q   [N_ENEMIES];
  en_e                     en_d   [N_ENEMIES];
  logic [CNT_W-1:0]        cnt_q  [N_ENEMIES];
  logic [CNT_W-1:0]        cnt_d  [N_ENEMIES];
  logic [STEP_W*N_ENEMIES-1:0] y_step_q, y_step_d;
  logic [N_ENEMIES-1:0]    airborne_q, airborne_d;
  logic [STEP_W-1:0]       step_k;

  // Detector presentation, live from the inputs selected by the scan index
  logic [LOC_W-1:0]        det_loc_c;
  logic [DIR_W-1:0]        det_dir_c;

  // Route the enemy under scan to the detector; idle presents zeros
  always_comb begin
    det_loc_c = '0;
    det_dir_c = '0;
    if (sch_q == SCH_SCAN) begin
      for (int k = 0; k < int'(N_ENEMIES); k++) begin
        if (idx_q == IDX_W'(k)) begin
          det_loc_c = bus.enemy_loc_all[LOC_W*k +: LOC_W];
          det_dir_c = bus.enemy_dir_all[DIR_W*k +: DIR_W];
        end
      end
    end
  end

  // Scheduler next state: walk every enemy once per frame, then one update cycle
  always_comb begin
    sch_d        = sch_q;
    idx_d        = idx_q;
    jump_flag_d  = jump_flag_q;
    overrun_d    = overrun_q;
    step_valid_d = 1'b0;
    unique case (sch_q)
      SCH_IDLE: begin
        if (bus.frame_tick) begin
          sch_d       = SCH_SCAN;
          idx_d       = '0;
          jump_flag_d = '0;
        end
      end
      SCH_SCAN: begin
        overrun_d = overrun_q | bus.frame_tick;
        for (int k = 0; k < int'(N_ENEMIES); k++) begin
          if (idx_q == IDX_W'(k)) begin
            jump_flag_d[k] = bus.det_jump;
          end
        end
        if (idx_q == IDX_W'(N_ENEMIES - 1)) begin
          sch_d = SCH_UPDATE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCH_UPDATE: begin
        overrun_d    = overrun_q | bus.frame_tick;
        step_valid_d = 1'b1;
        sch_d        = SCH_IDLE;
      end
      default: begin
        sch_d = SCH_IDLE;
      end
    endcase
    scan_busy_d = (sch_d != SCH_IDLE);
  end

  // Per-enemy jump/fall machines, advanced only in the update cycle
  always_comb begin
    for (int k = 0; k < int'(N_ENEMIES); k++) begin
      en_d[k]  = en_q[k];
      cnt_d[k] = cnt_q[k];
    end
    y_step_d   = y_step_q;
    airborne_d = airborne_q;
    step_k     = STEP_NONE;
    if (sch_q == SCH_UPDATE) begin
      for (int k = 0; k < int'(N_ENEMIES); k++) begin
        step_k = STEP_NONE;
        unique case (en_q[k])
          EN_GROUND: begin
            if (jump_flag_q[k]) begin
              en_d[k]  = EN_RISE;
              cnt_d[k] = RISE_INIT;
              step_k   = STEP_UP;
            end else if (!bus.enemy_grounded[k]) begin
              en_d[k] = EN_FALL;
              step_k  = STEP_DN;
            end
          end
          EN_RISE: begin
            // Entry frame already moved up once, so count the remaining frames
            if (cnt_q[k] != '0) begin
              cnt_d[k] = cnt_q[k] - CNT_W'(1);
              step_k   = STEP_UP;
            end else begin
              en_d[k] = EN_FALL;
              step_k  = STEP_DN;
            end
          end
          EN_FALL: begin
            if (bus.enemy_grounded[k]) begin
              en_d[k] = EN_GROUND;
            end else begin
              step_k = STEP_DN;
            end
          end
          default: begin
            en_d[k]  = EN_GROUND;
            cnt_d[k] = '0;
          end
        endcase
        y_step_d[STEP_W*k +: STEP_W] = step_k;
        airborne_d[k]                = (en_d[k] != EN_GROUND);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sch_q        <= SCH_IDLE;
      idx_q        <= '0;
      jump_flag_q  <= '0;
      overrun_q    <= 1'b0;
      scan_busy_q  <= 1'b0;
      step_valid_q <= 1'b0;
      y_step_q     <= '0;
      airborne_q   <= '0;
      for (int k = 0; k < int'(N_ENEMIES); k++) begin
        en_q[k]  <= EN_GROUND;
        cnt_q[k] <= '0;
      end
    end else begin
      sch_q        <= sch_d;
      idx_q        <= idx_d;
      jump_flag_q  <= jump_flag_d;
      overrun_q    <= overrun_d;
      scan_busy_q  <= scan_busy_d;
      step_valid_q <= step_valid_d;
      y_step_q     <= y_step_d;
      airborne_q   <= airborne_d;
      for (int k = 0; k < int'(N_ENEMIES); k++) begin
        en_q[k]  <= en_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.det_loc    = det_loc_c;
  assign bus.det_dir    = det_dir_c;
  assign bus.scan_busy  = scan_busy_q;
  assign bus.step_valid = step_valid_q;
  assign bus.y_step_all = y_step_q;
  assign bus.airborne   = airborne_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_enemy_jump_sched.sv
// Bench for enemy_jump_sched: a reference model predicts every frame's steps
// into a queue; a monitor pops and compares on each step_valid pulse.
module tb_enemy_jump_sched;

  localparam int N  = 4;
  localparam int RF = 8;
  localparam int JS = 2;
  localparam int FS = 2;

  typedef enum logic [1:0] {M_GROUND, M_RISE, M_FALL} m_e;

  typedef struct {
    logic [4*N-1:0] y;
    logic [N-1:0]   air;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] jump_req;

  m_e   m_st  [N];
  int   m_cnt [N];
  exp_t exp_q [$];
  exp_t mon_e;

  int tests_run = 0;
  int fails     = 0;

  enemy_jump_sched_if #(.N_ENEMIES(N)) bus ();

  enemy_jump_sched #(
    .N_ENEMIES  (N),
    .RISE_FRAMES(RF),
    .JUMP_STEP  (JS),
    .FALL_STEP  (FS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Detector stand-in: answers jump_req[k] when presented exactly enemy k
  always_comb begin
    bus.det_jump = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.det_loc == bus.enemy_loc_all[14*k +: 14] &&
          bus.det_dir == bus.enemy_dir_all[2*k +: 2])
        bus.det_jump = jump_req[k];
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.step_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: step_valid=1 with no frame outstanding, required 0");
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.y_step_all !== mon_e.y || bus.airborne !== mon_e.air) begin
          fails++;
          $display("FAIL sb_step: y_step_all=%h airborne=%b required y_step_all=%h airborne=%b",
                   bus.y_step_all, bus.airborne, mon_e.y, mon_e.air);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k]  = M_GROUND;
      m_cnt[k] = 0;
    end
  endtask

  // Reference behaviour for one frame
  task automatic model_frame(input logic [N-1:0] jmp, input logic [N-1:0] gnd);
    exp_t e;
    e.y   = '0;
    e.air = '0;
    for (int k = 0; k < N; k++) begin
      logic [3:0] s;
      s = 4'd0;
      case (m_st[k])
        M_GROUND: begin
          if (jmp[k]) begin
            m_st[k] = M_RISE; m_cnt[k] = RF - 1; s = 4'(-JS);
          end else if (!gnd[k]) begin
            m_st[k] = M_FALL; s = 4'(FS);
          end
        end
        M_RISE: begin
          if (m_cnt[k] > 0) begin
            m_cnt[k]--; s = 4'(-JS);
          end else begin
            m_st[k] = M_FALL; s = 4'(FS);
          end
        end
        default: begin
          if (gnd[k]) m_st[k] = M_GROUND;
          else s = 4'(FS);
        end
      endcase
      e.y[4*k +: 4] = s;
      e.air[k]      = (m_st[k] != M_GROUND);
    end
    exp_q.push_back(e);
  endtask

  // Set up inputs, predict, and issue a frame_tick sampled on the next edge
  task automatic tick_frame(input logic [N-1:0] jmp, input logic [N-1:0] gnd);
    jump_req           = jmp;
    bus.enemy_grounded = gnd;
    for (int k = 0; k < N; k++) begin
      bus.enemy_loc_all[14*k +: 14] = {3'(k + 1), 11'($urandom)};
      bus.enemy_dir_all[2*k +: 2]   = 2'(k % 3);
    end
    model_frame(jmp, gnd);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
  endtask

  task automatic drive_frame(input logic [N-1:0] jmp, input logic [N-1:0] gnd);
    tick_frame(jmp, gnd);
    repeat (N + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n              = 1'b1;
    bus.frame_tick     = 1'b0;
    bus.enemy_loc_all  = '0;
    bus.enemy_dir_all  = '0;
    bus.enemy_grounded = '1;
    jump_req           = '0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.det_loc !== 14'd0) begin fails++; $display("FAIL rst_det_loc: got %h required 0", bus.det_loc); end
    tests_run++; if (bus.det_dir !== 2'd0) begin fails++; $display("FAIL rst_det_dir: got %b required 00", bus.det_dir); end
    tests_run++; if (bus.scan_busy !== 1'b0) begin fails++; $display("FAIL rst_scan_busy: got %b required 0", bus.scan_busy); end
    tests_run++; if (bus.step_valid !== 1'b0) begin fails++; $display("FAIL rst_step_valid: got %b required 0", bus.step_valid); end
    tests_run++; if (bus.y_step_all !== 16'h0) begin fails++; $display("FAIL rst_y_step: got %h required 0", bus.y_step_all); end
    tests_run++; if (bus.airborne !== 4'b0) begin fails++; $display("FAIL rst_airborne: got %b required 0000", bus.airborne); end
    tests_run++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b required 0", bus.overrun); end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_frame();
    logic [13:0] exp_loc;
    logic [1:0]  exp_dir;
    tick_frame('0, '1);
    for (int j = 1; j <= N + 3; j++) begin
      @(negedge clk);
      exp_loc = (j <= N) ? bus.enemy_loc_all[14*(j-1) +: 14] : 14'd0;
      exp_dir = (j <= N) ? bus.enemy_dir_all[2*(j-1) +: 2] : 2'd0;
      tests_run++; if (bus.det_loc !== exp_loc) begin fails++; $display("FAIL scan_det_loc t+%0d: got %h required %h", j, bus.det_loc, exp_loc); end
      tests_run++; if (bus.det_dir !== exp_dir) begin fails++; $display("FAIL scan_det_dir t+%0d: got %b required %b", j, bus.det_dir, exp_dir); end
      tests_run++; if (bus.scan_busy !== (j <= N + 1)) begin fails++; $display("FAIL scan_busy t+%0d: got %b required %b", j, bus.scan_busy, (j <= N + 1)); end
      tests_run++; if (bus.step_valid !== (j == N + 2)) begin fails++; $display("FAIL step_valid_time t+%0d: got %b required %b", j, bus.step_valid, (j == N + 2)); end
    end
    tests_run++; if (bus.y_step_all !== 16'h0) begin fails++; $display("FAIL idle_y_step: got %h required 0", bus.y_step_all); end
    tests_run++; if (bus.airborne !== 4'b0) begin fails++; $display("FAIL idle_airborne: got %b required 0000", bus.airborne); end
  endtask

  task automatic test_jump_rise();
    logic [3:0] exp_s;
    for (int f = 0; f < 12; f++) begin
      drive_frame((f == 0) ? 4'b0100 : 4'b0000, (f == 0 || f == 11) ? 4'b1111 : 4'b1011);
      exp_s = (f < 8) ? 4'b1110 : (f < 11) ? 4'b0010 : 4'b0000;
      tests_run++; if (bus.y_step_all[11:8] !== exp_s) begin fails++; $display("FAIL rise_step f%0d: got %b required %b", f, bus.y_step_all[11:8], exp_s); end
      tests_run++; if (bus.airborne[2] !== (f < 11)) begin fails++; $display("FAIL rise_airborne f%0d: got %b required %b", f, bus.airborne[2], (f < 11)); end
    end
  endtask

  task automatic test_fall();
    logic [3:0] exp_s;
    for (int f = 0; f < 3; f++) begin
      drive_frame('0, (f < 2) ? 4'b1101 : 4'b1111);
      exp_s = (f < 2) ? 4'b0010 : 4'b0000;
      tests_run++; if (bus.y_step_all[7:4] !== exp_s) begin fails++; $display("FAIL fall_step f%0d: got %b required %b", f, bus.y_step_all[7:4], exp_s); end
      tests_run++; if (bus.airborne[1] !== (f < 2)) begin fails++; $display("FAIL fall_airborne f%0d: got %b required %b", f, bus.airborne[1], (f < 2)); end
    end
  endtask

  // Jump requests while rising or falling and grounded while rising are ignored
  task automatic test_jump_ignored();
    logic [3:0] exp_s;
    logic       jr;
    logic       gr;
    for (int f = 0; f < 11; f++) begin
      jr = (f == 0 || f == 3 || f == 5 || f == 9);
      gr = (f <= 8 || f == 10);
      drive_frame({jr, 3'b000}, {gr, 3'b111});
      exp_s = (f < 8) ? 4'b1110 : (f < 10) ? 4'b0010 : 4'b0000;
      tests_run++; if (bus.y_step_all[15:12] !== exp_s) begin fails++; $display("FAIL ignore_step f%0d: got %b required %b", f, bus.y_step_all[15:12], exp_s); end
      tests_run++; if (bus.airborne[3] !== (f < 10)) begin fails++; $display("FAIL ignore_airborne f%0d: got %b required %b", f, bus.airborne[3], (f < 10)); end
    end
  endtask

  task automatic test_back_to_back();
    tick_frame('0, '1);
    for (int j = 1; j <= N + 2; j++) @(negedge clk);
    tests_run++; if (bus.step_valid !== 1'b1) begin fails++; $display("FAIL b2b_first_valid: got %b required 1", bus.step_valid); end
    tick_frame(4'b0001, '1);
    for (int j = 1; j <= N + 3; j++) begin
      @(negedge clk);
      tests_run++; if (bus.scan_busy !== (j <= N + 1)) begin fails++; $display("FAIL b2b_scan_busy t+%0d: got %b required %b", j, bus.scan_busy, (j <= N + 1)); end
      tests_run++; if (bus.step_valid !== (j == N + 2)) begin fails++; $display("FAIL b2b_step_valid t+%0d: got %b required %b", j, bus.step_valid, (j == N + 2)); end
    end
    tests_run++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b required 0", bus.overrun); end
    tests_run++; if (bus.y_step_all[3:0] !== 4'b1110) begin fails++; $display("FAIL b2b_jump_step: got %b required 1110", bus.y_step_all[3:0]); end
  endtask

  task automatic test_overrun();
    tick_frame('0, '1);
    for (int j = 1; j <= N + 3; j++) begin
      @(negedge clk);
      tests_run++; if (bus.step_valid !== (j == N + 2)) begin fails++; $display("FAIL ovr_step_valid t+%0d: got %b required %b", j, bus.step_valid, (j == N + 2)); end
      tests_run++; if (bus.overrun !== (j >= 4)) begin fails++; $display("FAIL ovr_flag t+%0d: got %b required %b", j, bus.overrun, (j >= 4)); end
      if (j == 3) begin
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
      end
    end
    drive_frame('0, '1);
    tests_run++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b required 1", bus.overrun); end
  endtask

  task automatic test_reset_mid_scan();
    drive_frame('0, 4'b1101);
    tests_run++; if (bus.airborne[1] !== 1'b1) begin fails++; $display("FAIL mid_setup_airborne: got %b required 1", bus.airborne[1]); end
    tick_frame(4'b0001, 4'b1101);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.y_step_all !== 16'h0) begin fails++; $display("FAIL mid_y_step: got %h required 0", bus.y_step_all); end
    tests_run++; if (bus.airborne !== 4'b0) begin fails++; $display("FAIL mid_airborne: got %b required 0000", bus.airborne); end
    tests_run++; if (bus.scan_busy !== 1'b0) begin fails++; $display("FAIL mid_scan_busy: got %b required 0", bus.scan_busy); end
    tests_run++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL mid_overrun: got %b required 0", bus.overrun); end
    tests_run++; if (bus.det_loc !== 14'd0) begin fails++; $display("FAIL mid_det_loc: got %h required 0", bus.det_loc); end
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      tests_run++; if (bus.step_valid !== 1'b0) begin fails++; $display("FAIL mid_no_valid c%0d: got %b required 0", j, bus.step_valid); end
    end
    drive_frame('0, '1);
    tests_run++; if (bus.y_step_all !== 16'h0) begin fails++; $display("FAIL mid_after_y_step: got %h required 0", bus.y_step_all); end
    tests_run++; if (bus.airborne !== 4'b0) begin fails++; $display("FAIL mid_after_airborne: got %b required 0000", bus.airborne); end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_jump_rise();
    test_fall();
    test_jump_ignored();
    test_back_to_back();
    test_overrun();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d frames outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
